// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port DMEM between the core data port (0)
// and a debug/DMA port (1), with a bounded lock for back-to-back bursts.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 256,
  parameter int ADDR_BITS  = 8,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_0,
  input  logic                  we_0,
  input  logic                  lock_0,
  input  logic [31:0]           addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  gnt_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic                  rvalid_0,
  input  logic                  req_1,
  input  logic                  we_1,
  input  logic                  lock_1,
  input  logic [31:0]           addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  gnt_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  rvalid_1,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_TOP = LCW'(MAX_LOCK - 1);

  state_t         state, state_nxt, oth_st;
  logic           last, last_nxt;
  logic [LCW-1:0] lock_cnt, lock_cnt_nxt;
  logic           xfer_0, xfer_1, xfer, own, req_oth, lock_own;
  logic           unused_addr;

  assign gnt_0    = (state == OWN0);
  assign gnt_1    = (state == OWN1);
  assign xfer_0   = gnt_0 && req_0;
  assign xfer_1   = gnt_1 && req_1;
  assign xfer     = xfer_0 || xfer_1;
  assign own      = gnt_1;
  assign req_oth  = own ? req_0 : req_1;
  assign lock_own = own ? lock_1 : lock_0;
  assign oth_st   = own ? OWN0 : OWN1;

  // Address/data mux follows the owner (requester 0 when idle); only a transfer writes.
  assign mem_addr  = gnt_1 ? addr_1[ADDR_BITS+1:2] : addr_0[ADDR_BITS+1:2];
  assign mem_wdata = gnt_1 ? wdata_1 : wdata_0;
  assign mem_we    = (xfer_0 && we_0) || (xfer_1 && we_1);

  assign unused_addr = ^{addr_0[31:ADDR_BITS+2], addr_0[1:0], addr_1[31:ADDR_BITS+2], addr_1[1:0]};

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    last_nxt     = xfer ? own : last;
    case (state)
      IDLE: begin
        lock_cnt_nxt = '0;
        if (req_0 && req_1) state_nxt = last ? OWN0 : OWN1;
        else if (req_0)     state_nxt = OWN0;
        else if (req_1)     state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (xfer && lock_own && lock_cnt != LOCK_TOP) begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end else if (xfer && lock_own && !req_oth) begin
          // lock saturated but nobody else waiting: keep ownership, hold count
          lock_cnt_nxt = lock_cnt;
        end else begin
          lock_cnt_nxt = '0;
          if (req_oth)    state_nxt = oth_st;
          else if (!xfer) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      rdata_0  <= '0;
      rdata_1  <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= lock_cnt_nxt;
      rvalid_0 <= xfer_0 && !we_0;
      rvalid_1 <= xfer_1 && !we_1;
      if (xfer_0 && !we_0) rdata_0 <= mem_rdata;
      if (xfer_1 && !we_1) rdata_1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + random bench for dmem_arbiter against an owner/run-length reference
// model with its own copy of memory contents.
module tb_dmem_arbiter;
  localparam int DW       = 32;
  localparam int MEM_SIZE = 256;
  localparam int AB       = 8;
  localparam int MAX_LOCK = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_0, we_0, lock_0, req_1, we_1, lock_1;
  logic [31:0]   addr_0, addr_1;
  logic [DW-1:0] wdata_0, wdata_1, rdata_0, rdata_1, mem_wdata, mem_rdata;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1, mem_we;
  logic [AB-1:0] mem_addr;

  logic [DW-1:0] dmem [MEM_SIZE];

  int compared   = 0;
  int mismatched = 0;

  // reference state: owner -1 means nobody holds DMEM
  int            m_own, m_run, m_last;
  bit            m_rv [2];
  logic [DW-1:0] m_rd [2];
  logic [DW-1:0] ref_mem [MEM_SIZE];

  dmem_arbiter #(.DATA_WIDTH(DW), .MEM_SIZE(MEM_SIZE), .ADDR_BITS(AB), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rdata_0(rdata_0), .rvalid_0(rvalid_0),
    .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rdata_1(rdata_1), .rvalid_1(rvalid_1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_run = 0; m_last = 1;
    m_rv  = '{1'b0, 1'b0};
    m_rd  = '{'0, '0};
  endtask

  // One clock: check outputs against the model mid-cycle, advance model, move to next negedge.
  task automatic cyc();
    bit            rq [2], wv [2], lk [2];
    logic [31:0]   ad [2];
    logic [DW-1:0] wd [2];
    int            o, p, idx;
    bit            x;
    rq = '{req_0, req_1}; wv = '{we_0, we_1}; lk = '{lock_0, lock_1};
    ad = '{addr_0, addr_1}; wd = '{wdata_0, wdata_1};
    #1;
    o   = m_own;
    p   = (o < 0) ? 0 : o;
    x   = (o >= 0) && rq[p];
    idx = int'((ad[p] >> 2) % MEM_SIZE);
    chk("gnt_0", gnt_0, m_own == 0);
    chk("gnt_1", gnt_1, m_own == 1);
    chk("rvalid_0", rvalid_0, m_rv[0]);
    chk("rvalid_1", rvalid_1, m_rv[1]);
    chk("rdata_0", rdata_0, m_rd[0]);
    chk("rdata_1", rdata_1, m_rd[1]);
    chk("mem_we", mem_we, x && wv[p]);
    chk("mem_addr", mem_addr, idx);
    chk("mem_wdata", mem_wdata, wd[p]);
    m_rv = '{1'b0, 1'b0};
    if (x) begin
      if (wv[p]) ref_mem[idx] = wd[p];
      else begin m_rv[p] = 1'b1; m_rd[p] = ref_mem[idx]; end
      m_last = p;
    end
    if (o < 0) begin
      if (rq[0] && rq[1]) m_own = 1 - m_last;
      else if (rq[0])     m_own = 0;
      else if (rq[1])     m_own = 1;
      m_run = 0;
    end else if (x && lk[p] && (m_run < MAX_LOCK - 1 || !rq[1-p])) begin
      m_run = (m_run + 1 > MAX_LOCK - 1) ? MAX_LOCK - 1 : m_run + 1;
    end else begin
      m_run = 0;
      if (rq[1-p]) m_own = 1 - p;
      else if (!x) m_own = -1;
    end
    @(negedge clk);
  endtask

  // Assert reset mid-cycle, check the immediate effect, release on the next negedge.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_gnt_0", gnt_0, 0);
    chk("rst_gnt_1", gnt_1, 0);
    chk("rst_rvalid_0", rvalid_0, 0);
    chk("rst_rvalid_1", rvalid_1, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rdata_0", rdata_0, 0);
    chk("rst_rdata_1", rdata_1, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    req_0 = 0; we_0 = 0; lock_0 = 0; addr_0 = '0; wdata_0 = '0;
    req_1 = 0; we_1 = 0; lock_1 = 0; addr_1 = '0; wdata_1 = '0;
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) begin dmem[i] = '0; ref_mem[i] = '0; end
    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk("por_gnt_0", gnt_0, 0);
    chk("por_gnt_1", gnt_1, 0);
    chk("por_rvalid_0", rvalid_0, 0);
    chk("por_rdata_0", rdata_0, 0);
    chk("por_mem_we", mem_we, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // write 0xDEADBEEF to 0x10, then read it back
    req_0 = 1; we_0 = 1; addr_0 = 32'h10; wdata_0 = 32'hDEADBEEF;
    cyc();
    chk("wr_addr", mem_addr, 4);
    chk("wr_we", mem_we, 1);
    cyc();
    we_0 = 0;
    cyc();
    req_0 = 0;
    chk("rd_rvalid_0", rvalid_0, 1);
    chk("rd_rdata_0", rdata_0, 32'hDEADBEEF);
    cyc();

    // reset during a write transfer: write must be dropped
    req_0 = 1; we_0 = 1; addr_0 = 32'h10; wdata_0 = 32'h12345678;
    cyc();
    do_reset();
    we_0 = 0;
    cyc();
    cyc();
    req_0 = 0;
    chk("drop_rdata_0", rdata_0, 32'hDEADBEEF);
    cyc();

    // simultaneous unlocked requests alternate 0,1,0,1
    do_reset();
    req_0 = 1; req_1 = 1; addr_1 = 32'h20;
    cyc();
    chk("rr_0", gnt_0, 1); cyc();
    chk("rr_1", gnt_1, 1); cyc();
    chk("rr_2", gnt_0, 1); cyc();
    chk("rr_3", gnt_1, 1); cyc();

    // lock bound: requester 1 holds at most MAX_LOCK transfers
    do_reset();
    req_0 = 1; req_1 = 1; lock_1 = 1;
    cyc();
    chk("lk_first0", gnt_0, 1); cyc();
    for (int i = 0; i < MAX_LOCK; i++) begin
      chk("lk_hold1", gnt_1, 1); cyc();
    end
    chk("lk_release0", gnt_0, 1); cyc();

    // lock release after two locked transfers
    do_reset();
    idle_inputs();
    req_0 = 1; lock_0 = 1; req_1 = 1;
    cyc();
    cyc();
    cyc();
    lock_0 = 0;
    chk("rel_own0", gnt_0, 1);
    cyc();
    chk("rel_gnt_1", gnt_1, 1);
    req_0 = 0;
    cyc();

    // address wrap: byte 0x400 maps to word 0
    do_reset();
    idle_inputs();
    req_1 = 1; we_1 = 1; addr_1 = 32'h400; wdata_1 = 32'h55;
    cyc();
    chk("wrap_addr", mem_addr, 0);
    chk("wrap_we", mem_we, 1);
    cyc();
    we_1 = 0; addr_1 = 32'h0;
    cyc();
    req_1 = 0;
    chk("wrap_rdata_1", rdata_1, 32'h55);
    cyc();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      req_0 = ($urandom_range(0, 3) != 0); we_0 = $urandom_range(0, 1) == 1;
      lock_0 = ($urandom_range(0, 2) == 0); addr_0 = $urandom; wdata_0 = $urandom;
      req_1 = ($urandom_range(0, 3) != 0); we_1 = $urandom_range(0, 1) == 1;
      lock_1 = ($urandom_range(0, 2) == 0); addr_1 = $urandom; wdata_1 = $urandom;
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
